// File: rtl/conv_padding_loop_ctrl.sv
// conv_padding_loop_ctrl
// ----------------------------------------------------------------------------
// Hardware loop sequencer for the channel-padding dataflow of the compute
// cluster. It walks the loop nest z(chunk) > fy > fx > oy > ox, using runtime
// dimensions and stride that are latched at start. While the cluster works on
// one step, the chunk for the next step is prefetched into the idle half of
// the double-buffered IFM and filter chunk RAMs. One total_chunk_start pulse
// is issued per step.
//
// Ports
//   clk_i, rst_i              clock, asynchronous active-low reset
//   start_i                   run start pulse (accepted only when idle)
//   cfg_*_i                   channel count, IFM/filter/output dims, stride
//   busy_o, done_o            run in progress / 1-cycle completion pulse
//   ifm_chunk_wr_*_o          IFM chunk write beat, beat index, buffer halves
//   ifm_sram_rd_count_o       IFM SRAM chunk index being copied
//   fil_chunk_wr_*_o          filter chunk write beat, beat index, halves
//   fil_chunk_cu_wr_sel_o     one-hot compute unit receiving the filter chunk
//   fil_sram_rd_count_o       filter SRAM index (fil_idx*CU_NUM + cu)
//   run_valid_o               high from the first step until done
//   total_chunk_start_o       starts one step in the cluster
//   total_chunk_end_i         step finished in the cluster
//   rd_fil_sparsemap_last_o   beats-1 of the current step's chunk
//   acc_buf_sel_o             accumulation buffer (oy*out_x + ox)
// ----------------------------------------------------------------------------
module conv_padding_loop_ctrl #(
    parameter int unsigned BUS_SIZE    = 32,
    parameter int unsigned CHUNK_SIZE  = 128,
    parameter int unsigned CU_NUM      = 4,
    parameter int unsigned DIM_W       = 8,
    parameter int unsigned OUT_BUF_NUM = 64,
    parameter int unsigned IFM_AW      = 16,
    parameter int unsigned FIL_AW      = 12
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    start_i,
    input  logic [DIM_W-1:0]                        cfg_ch_i,
    input  logic [DIM_W-1:0]                        cfg_ifm_x_i,
    input  logic [DIM_W-1:0]                        cfg_ifm_y_i,
    input  logic [DIM_W-1:0]                        cfg_fil_x_i,
    input  logic [DIM_W-1:0]                        cfg_fil_y_i,
    input  logic [DIM_W-1:0]                        cfg_out_x_i,
    input  logic [DIM_W-1:0]                        cfg_out_y_i,
    input  logic [1:0]                              cfg_stride_i,
    output logic                                    busy_o,
    output logic                                    done_o,
    output logic                                    ifm_chunk_wr_valid_o,
    output logic [$clog2(CHUNK_SIZE/BUS_SIZE)-1:0]  ifm_chunk_wr_count_o,
    output logic                                    ifm_chunk_wr_sel_o,
    output logic                                    ifm_chunk_rd_sel_o,
    output logic [IFM_AW-1:0]                       ifm_sram_rd_count_o,
    output logic                                    fil_chunk_wr_valid_o,
    output logic [$clog2(CHUNK_SIZE/BUS_SIZE)-1:0]  fil_chunk_wr_count_o,
    output logic                                    fil_chunk_wr_sel_o,
    output logic                                    fil_chunk_rd_sel_o,
    output logic [CU_NUM-1:0]                       fil_chunk_cu_wr_sel_o,
    output logic [FIL_AW-1:0]                       fil_sram_rd_count_o,
    output logic                                    run_valid_o,
    output logic                                    total_chunk_start_o,
    input  logic                                    total_chunk_end_i,
    output logic [$clog2(CHUNK_SIZE/BUS_SIZE)-1:0]  rd_fil_sparsemap_last_o,
    output logic [$clog2(OUT_BUF_NUM)-1:0]          acc_buf_sel_o
);

    localparam int unsigned BEAT_W = $clog2(CHUNK_SIZE/BUS_SIZE);
    localparam int unsigned CU_W   = (CU_NUM > 1) ? $clog2(CU_NUM) : 1;
    localparam int unsigned ACC_W  = $clog2(OUT_BUF_NUM);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRELOAD,
        S_STALL,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    // latched configuration
    logic [DIM_W-1:0] ch_q, ifm_x_q, ifm_y_q, fil_x_q, fil_y_q, out_x_q, out_y_q;
    logic [1:0]       stride_q;

    // current step
    logic [DIM_W-1:0] cur_z, cur_fy, cur_fx, cur_oy, cur_ox;
    // step following the current one
    logic [DIM_W-1:0] n_z, n_fy, n_fx, n_oy, n_ox;
    // step whose chunks are being kicked this cycle
    logic [DIM_W-1:0] k_z, k_fy, k_fx, k_oy, k_ox;

    logic [DIM_W-1:0] z_max, fy_max, fx_max, oy_max, ox_max;
    logic [1:0]       stride_eff;
    logic             is_last;
    logic             fil_change;
    logic             kick_ifm, kick_fil;

    logic [IFM_AW-1:0] k_iy, k_ix, k_ifm_idx;
    logic [FIL_AW-1:0] k_fil_idx, k_fil_base;
    logic [BEAT_W-1:0] k_beat_last, cur_beat_last;

    logic              run_valid_q;
    logic [ACC_W-1:0]  acc_q;
    logic [BEAT_W-1:0] spm_last_q;

    // IFM copy engine
    logic              ifm_busy_q;
    logic [BEAT_W-1:0] ifm_cnt_q, ifm_last_q;
    logic [IFM_AW-1:0] ifm_addr_q;
    logic              ifm_wr_sel_q;

    // filter copy engine
    logic              fil_busy_q;
    logic [BEAT_W-1:0] fil_cnt_q, fil_last_q;
    logic [CU_W-1:0]   fil_cu_q;
    logic [FIL_AW-1:0] fil_base_q;
    logic              fil_wr_sel_q;
    logic [CU_NUM-1:0] cu_one;

    function automatic logic [DIM_W-1:0] dim_max(input logic [DIM_W-1:0] d);
        return (d == '0) ? '0 : d - DIM_W'(1);
    endfunction

    // Beats-1 of chunk z: full chunks except the last, whose size is the
    // channel remainder (a zero remainder means a full chunk).
    function automatic logic [BEAT_W-1:0] beat_last(input logic [DIM_W-1:0] z,
                                                    input logic [DIM_W-1:0] ch,
                                                    input logic [DIM_W-1:0] zmax);
        int unsigned rem;
        int unsigned size;
        rem  = 32'(ch) % CHUNK_SIZE;
        size = ((z < zmax) || (rem == 0)) ? CHUNK_SIZE : rem;
        return BEAT_W'((size + BUS_SIZE - 1) / BUS_SIZE - 1);
    endfunction

    // ------------------------------------------------------------------
    // Loop bounds and step arithmetic
    // ------------------------------------------------------------------
    always_comb begin
        z_max      = (ch_q == '0) ? '0 : DIM_W'((32'(ch_q) - 32'd1) / CHUNK_SIZE);
        fy_max     = dim_max(fil_y_q);
        fx_max     = dim_max(fil_x_q);
        oy_max     = dim_max(out_y_q);
        ox_max     = dim_max(out_x_q);
        stride_eff = (stride_q == 2'd0) ? 2'd1 : stride_q;
    end

    always_comb begin
        n_z  = cur_z;
        n_fy = cur_fy;
        n_fx = cur_fx;
        n_oy = cur_oy;
        n_ox = cur_ox;
        if (cur_ox != ox_max) begin
            n_ox = cur_ox + DIM_W'(1);
        end else begin
            n_ox = '0;
            if (cur_oy != oy_max) begin
                n_oy = cur_oy + DIM_W'(1);
            end else begin
                n_oy = '0;
                if (cur_fx != fx_max) begin
                    n_fx = cur_fx + DIM_W'(1);
                end else begin
                    n_fx = '0;
                    if (cur_fy != fy_max) begin
                        n_fy = cur_fy + DIM_W'(1);
                    end else begin
                        n_fy = '0;
                        n_z  = cur_z + DIM_W'(1);
                    end
                end
            end
        end
        is_last    = (cur_z == z_max) && (cur_fy == fy_max) && (cur_fx == fx_max) &&
                     (cur_oy == oy_max) && (cur_ox == ox_max);
        fil_change = (n_z != cur_z) || (n_fy != cur_fy) || (n_fx != cur_fx);
    end

    // PRELOAD kicks the current (first) step, ISSUE kicks the next one.
    always_comb begin
        if (state_q == S_ISSUE) begin
            k_z  = n_z;
            k_fy = n_fy;
            k_fx = n_fx;
            k_oy = n_oy;
            k_ox = n_ox;
        end else begin
            k_z  = cur_z;
            k_fy = cur_fy;
            k_fx = cur_fx;
            k_oy = cur_oy;
            k_ox = cur_ox;
        end
        k_iy       = IFM_AW'(k_fy) + IFM_AW'(k_oy) * IFM_AW'(stride_eff);
        k_ix       = IFM_AW'(k_fx) + IFM_AW'(k_ox) * IFM_AW'(stride_eff);
        k_ifm_idx  = (IFM_AW'(k_z) * IFM_AW'(ifm_y_q) + k_iy) * IFM_AW'(ifm_x_q) + k_ix;
        k_fil_idx  = (FIL_AW'(k_z) * FIL_AW'(fil_y_q) + FIL_AW'(k_fy)) * FIL_AW'(fil_x_q)
                     + FIL_AW'(k_fx);
        k_fil_base = k_fil_idx * FIL_AW'(CU_NUM);
        k_beat_last   = beat_last(k_z, ch_q, z_max);
        cur_beat_last = beat_last(cur_z, ch_q, z_max);
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    // PRELOAD only kicks; the wait for the first prefetch reuses STALL,
    // since the engines do not report busy until the cycle after a kick.
    always_comb begin
        state_d  = state_q;
        kick_ifm = 1'b0;
        kick_fil = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_PRELOAD;
            end
            S_PRELOAD: begin
                kick_ifm = 1'b1;
                kick_fil = 1'b1;
                state_d  = S_STALL;
            end
            S_STALL: begin
                if (!ifm_busy_q && !fil_busy_q) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (!is_last) begin
                    kick_ifm = 1'b1;
                    kick_fil = fil_change;
                end
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (total_chunk_end_i) state_d = is_last ? S_DONE : S_STALL;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            ifm_x_q     <= '0;
            ifm_y_q     <= '0;
            fil_x_q     <= '0;
            fil_y_q     <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            stride_q    <= '0;
            cur_z       <= '0;
            cur_fy      <= '0;
            cur_fx      <= '0;
            cur_oy      <= '0;
            cur_ox      <= '0;
            run_valid_q <= 1'b0;
            acc_q       <= '0;
            spm_last_q  <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == S_IDLE) && start_i) begin
                ch_q     <= cfg_ch_i;
                ifm_x_q  <= cfg_ifm_x_i;
                ifm_y_q  <= cfg_ifm_y_i;
                fil_x_q  <= cfg_fil_x_i;
                fil_y_q  <= cfg_fil_y_i;
                out_x_q  <= cfg_out_x_i;
                out_y_q  <= cfg_out_y_i;
                stride_q <= cfg_stride_i;
                cur_z    <= '0;
                cur_fy   <= '0;
                cur_fx   <= '0;
                cur_oy   <= '0;
                cur_ox   <= '0;
            end
            if ((state_q == S_WAIT) && total_chunk_end_i) begin
                if (is_last) begin
                    run_valid_q <= 1'b0;
                end else begin
                    cur_z  <= n_z;
                    cur_fy <= n_fy;
                    cur_fx <= n_fx;
                    cur_oy <= n_oy;
                    cur_ox <= n_ox;
                end
            end
            // step attributes are loaded on entry so they are valid
            // together with the start pulse
            if ((state_q == S_STALL) && (state_d == S_ISSUE)) begin
                run_valid_q <= 1'b1;
                acc_q       <= ACC_W'(32'(cur_oy) * 32'(out_x_q) + 32'(cur_ox));
                spm_last_q  <= cur_beat_last;
            end
        end
    end

    // ------------------------------------------------------------------
    // IFM copy engine: one chunk, `beats` write cycles
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ifm_busy_q   <= 1'b0;
            ifm_cnt_q    <= '0;
            ifm_last_q   <= '0;
            ifm_addr_q   <= '0;
            ifm_wr_sel_q <= 1'b1;
        end else if (kick_ifm) begin
            ifm_busy_q   <= 1'b1;
            ifm_cnt_q    <= '0;
            ifm_last_q   <= k_beat_last;
            ifm_addr_q   <= k_ifm_idx;
            ifm_wr_sel_q <= ~ifm_wr_sel_q;
        end else if (ifm_busy_q) begin
            if (ifm_cnt_q == ifm_last_q) ifm_busy_q <= 1'b0;
            else                         ifm_cnt_q  <= ifm_cnt_q + BEAT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Filter copy engine: the same chunk written once per compute unit
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fil_busy_q   <= 1'b0;
            fil_cnt_q    <= '0;
            fil_last_q   <= '0;
            fil_cu_q     <= '0;
            fil_base_q   <= '0;
            fil_wr_sel_q <= 1'b1;
        end else if (kick_fil) begin
            fil_busy_q   <= 1'b1;
            fil_cnt_q    <= '0;
            fil_last_q   <= k_beat_last;
            fil_cu_q     <= '0;
            fil_base_q   <= k_fil_base;
            fil_wr_sel_q <= ~fil_wr_sel_q;
        end else if (fil_busy_q) begin
            if (fil_cnt_q == fil_last_q) begin
                fil_cnt_q <= '0;
                if (fil_cu_q == CU_W'(CU_NUM - 1)) fil_busy_q <= 1'b0;
                else                               fil_cu_q   <= fil_cu_q + CU_W'(1);
            end else begin
                fil_cnt_q <= fil_cnt_q + BEAT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cu_one = CU_NUM'(1);

    assign busy_o                  = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o                  = (state_q == S_DONE);
    assign total_chunk_start_o     = (state_q == S_ISSUE);
    assign run_valid_o             = run_valid_q;
    assign acc_buf_sel_o           = acc_q;
    assign rd_fil_sparsemap_last_o = spm_last_q;

    assign ifm_chunk_wr_valid_o = ifm_busy_q;
    assign ifm_chunk_wr_count_o = ifm_cnt_q;
    assign ifm_chunk_wr_sel_o   = ifm_wr_sel_q;
    assign ifm_chunk_rd_sel_o   = ~ifm_wr_sel_q;
    assign ifm_sram_rd_count_o  = ifm_addr_q;

    assign fil_chunk_wr_valid_o  = fil_busy_q;
    assign fil_chunk_wr_count_o  = fil_cnt_q;
    assign fil_chunk_wr_sel_o    = fil_wr_sel_q;
    assign fil_chunk_rd_sel_o    = ~fil_wr_sel_q;
    assign fil_chunk_cu_wr_sel_o = fil_busy_q ? (cu_one << fil_cu_q) : '0;
    assign fil_sram_rd_count_o   = fil_base_q + FIL_AW'(fil_cu_q);

endmodule

// File: tb/tb_conv_padding_loop_ctrl.sv
// Scoreboard bench for conv_padding_loop_ctrl. A loop-nest reference model
// fills expectation queues for step starts, IFM beats and filter beats; a
// monitor pops and compares whatever the DUT presents. A cluster model
// answers each start with an end pulse after a random delay.
module tb_conv_padding_loop_ctrl;

    localparam int BUS   = 32;
    localparam int CHUNK = 128;
    localparam int CU    = 4;

    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic       start_i = 1'b0;
    logic [7:0] cfg_ch = '0, cfg_ifm_x = '0, cfg_ifm_y = '0, cfg_fil_x = '0, cfg_fil_y = '0;
    logic [7:0] cfg_out_x = '0, cfg_out_y = '0;
    logic [1:0] cfg_stride = '0;
    logic       busy_o, done_o;
    logic       ifm_chunk_wr_valid_o, ifm_chunk_wr_sel_o, ifm_chunk_rd_sel_o;
    logic [1:0] ifm_chunk_wr_count_o;
    logic [15:0] ifm_sram_rd_count_o;
    logic       fil_chunk_wr_valid_o, fil_chunk_wr_sel_o, fil_chunk_rd_sel_o;
    logic [1:0] fil_chunk_wr_count_o;
    logic [3:0] fil_chunk_cu_wr_sel_o;
    logic [11:0] fil_sram_rd_count_o;
    logic       run_valid_o, total_chunk_start_o;
    logic       resp_end = 1'b0, spur_end = 1'b0, total_chunk_end_i;
    logic [1:0] rd_fil_sparsemap_last_o;
    logic [5:0] acc_buf_sel_o;

    assign total_chunk_end_i = resp_end | spur_end;

    always #5 clk = ~clk;

    conv_padding_loop_ctrl #(
        .BUS_SIZE(32), .CHUNK_SIZE(128), .CU_NUM(4), .DIM_W(8),
        .OUT_BUF_NUM(64), .IFM_AW(16), .FIL_AW(12)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .cfg_ch_i(cfg_ch), .cfg_ifm_x_i(cfg_ifm_x), .cfg_ifm_y_i(cfg_ifm_y),
        .cfg_fil_x_i(cfg_fil_x), .cfg_fil_y_i(cfg_fil_y),
        .cfg_out_x_i(cfg_out_x), .cfg_out_y_i(cfg_out_y), .cfg_stride_i(cfg_stride),
        .busy_o(busy_o), .done_o(done_o),
        .ifm_chunk_wr_valid_o(ifm_chunk_wr_valid_o), .ifm_chunk_wr_count_o(ifm_chunk_wr_count_o),
        .ifm_chunk_wr_sel_o(ifm_chunk_wr_sel_o), .ifm_chunk_rd_sel_o(ifm_chunk_rd_sel_o),
        .ifm_sram_rd_count_o(ifm_sram_rd_count_o),
        .fil_chunk_wr_valid_o(fil_chunk_wr_valid_o), .fil_chunk_wr_count_o(fil_chunk_wr_count_o),
        .fil_chunk_wr_sel_o(fil_chunk_wr_sel_o), .fil_chunk_rd_sel_o(fil_chunk_rd_sel_o),
        .fil_chunk_cu_wr_sel_o(fil_chunk_cu_wr_sel_o), .fil_sram_rd_count_o(fil_sram_rd_count_o),
        .run_valid_o(run_valid_o), .total_chunk_start_o(total_chunk_start_o),
        .total_chunk_end_i(total_chunk_end_i),
        .rd_fil_sparsemap_last_o(rd_fil_sparsemap_last_o), .acc_buf_sel_o(acc_buf_sel_o)
    );

    typedef struct { int acc; int last; int ifm_cum; int fil_cum; int ifm_par; int fil_par; } st_exp_t;
    typedef struct { int addr; int cnt; } ifm_exp_t;
    typedef struct { int addr; int cu1h; int cnt; } fil_exp_t;

    st_exp_t  st_q[$];
    ifm_exp_t ifm_q[$];
    fil_exp_t fil_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int ifm_seen = 0, fil_seen = 0, done_cnt = 0, start_seen = 0;
    int ifm_base = 1, fil_base = 1;
    bit cluster_en = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int beats_of(input int z, input int nz, input int ch);
        int size;
        if (z < nz - 1 || ch % CHUNK == 0) size = CHUNK;
        else                               size = ch % CHUNK;
        return (size + BUS - 1) / BUS;
    endfunction

    // Reference model: plain loop nest producing every expected event in order.
    task automatic build(input int ch, input int ixd, input int iyd, input int fxd, input int fyd,
                         input int oxd, input int oyd, input int s,
                         output int nsteps, output int ngroups);
        int nz, se, ifm_cum, fil_cum, b, fidx;
        st_exp_t  se_e;
        ifm_exp_t ie;
        fil_exp_t fe;
        nz = (ch + CHUNK - 1) / CHUNK;
        se = (s == 0) ? 1 : s;
        ifm_cum = 0; fil_cum = 0; nsteps = 0; ngroups = 0;
        for (int z = 0; z < nz; z++)
            for (int fy = 0; fy < fyd; fy++)
                for (int fx = 0; fx < fxd; fx++) begin
                    b = beats_of(z, nz, ch);
                    fidx = (z * fyd + fy) * fxd + fx;
                    ngroups++;
                    for (int cu = 0; cu < CU; cu++)
                        for (int k = 0; k < b; k++) begin
                            fe.addr = (fidx * CU + cu) % 4096;
                            fe.cu1h = 1 << cu;
                            fe.cnt  = k;
                            fil_q.push_back(fe);
                        end
                    fil_cum += CU * b;
                    for (int oy = 0; oy < oyd; oy++)
                        for (int ox = 0; ox < oxd; ox++) begin
                            for (int k = 0; k < b; k++) begin
                                ie.addr = ((z * iyd + fy + oy * se) * ixd + fx + ox * se) % 65536;
                                ie.cnt  = k;
                                ifm_q.push_back(ie);
                            end
                            ifm_cum += b;
                            nsteps++;
                            se_e.acc     = (oy * oxd + ox) % 64;
                            se_e.last    = b - 1;
                            se_e.ifm_cum = ifm_cum;
                            se_e.fil_cum = fil_cum;
                            se_e.ifm_par = nsteps % 2;
                            se_e.fil_par = ngroups % 2;
                            st_q.push_back(se_e);
                        end
                end
    endtask

    task automatic flush();
        st_q.delete();
        ifm_q.delete();
        fil_q.delete();
    endtask

    // Monitor: pop and compare on every DUT event.
    initial forever begin
        st_exp_t  e;
        ifm_exp_t ie;
        fil_exp_t fe;
        @(negedge clk);
        if (rst_i) begin
            if (total_chunk_start_o) begin
                start_seen++;
                if (st_q.size() == 0) chk("unexpected_start", 1, 0);
                else begin
                    e = st_q.pop_front();
                    chk("acc_buf_sel", int'(acc_buf_sel_o), e.acc);
                    chk("sparsemap_last", int'(rd_fil_sparsemap_last_o), e.last);
                    chk("ifm_prefetch_beats", ifm_seen, e.ifm_cum);
                    chk("fil_prefetch_beats", fil_seen, e.fil_cum);
                    chk("ifm_wr_sel_at_start", int'(ifm_chunk_wr_sel_o), ifm_base ^ e.ifm_par);
                    chk("fil_wr_sel_at_start", int'(fil_chunk_wr_sel_o), fil_base ^ e.fil_par);
                    chk("run_valid_at_start", int'(run_valid_o), 1);
                end
            end
            if (ifm_chunk_wr_valid_o) begin
                ifm_seen++;
                chk("ifm_sel_complement", int'(ifm_chunk_wr_sel_o ^ ifm_chunk_rd_sel_o), 1);
                if (ifm_q.size() == 0) chk("unexpected_ifm_beat", 1, 0);
                else begin
                    ie = ifm_q.pop_front();
                    chk("ifm_sram_rd_count", int'(ifm_sram_rd_count_o), ie.addr);
                    chk("ifm_wr_count", int'(ifm_chunk_wr_count_o), ie.cnt);
                end
            end
            if (fil_chunk_wr_valid_o) begin
                fil_seen++;
                chk("fil_sel_complement", int'(fil_chunk_wr_sel_o ^ fil_chunk_rd_sel_o), 1);
                if (fil_q.size() == 0) chk("unexpected_fil_beat", 1, 0);
                else begin
                    fe = fil_q.pop_front();
                    chk("fil_sram_rd_count", int'(fil_sram_rd_count_o), fe.addr);
                    chk("fil_cu_wr_sel", int'(fil_chunk_cu_wr_sel_o), fe.cu1h);
                    chk("fil_wr_count", int'(fil_chunk_wr_count_o), fe.cnt);
                end
            end
            if (done_o) begin
                done_cnt++;
                chk("done_run_valid", int'(run_valid_o), 0);
                chk("done_busy", int'(busy_o), 0);
            end
        end
    end

    // Cluster model: end pulse 1..4 cycles after each start.
    initial forever begin
        int d;
        @(negedge clk);
        if (total_chunk_start_o && cluster_en && rst_i) begin
            d = $urandom_range(1, 4);
            repeat (d) @(negedge clk);
            resp_end = 1'b1;
            @(negedge clk);
            resp_end = 1'b0;
        end
    end

    task automatic kick_start(input int ch, input int ixd, input int iyd, input int fxd, input int fyd,
                              input int oxd, input int oyd, input int s, input bit spur);
        @(negedge clk);
        cfg_ch = 8'(ch); cfg_ifm_x = 8'(ixd); cfg_ifm_y = 8'(iyd);
        cfg_fil_x = 8'(fxd); cfg_fil_y = 8'(fyd);
        cfg_out_x = 8'(oxd); cfg_out_y = 8'(oyd); cfg_stride = 2'(s);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        // configuration must be latched: scramble the inputs
        cfg_ch = 8'($urandom); cfg_ifm_x = 8'($urandom); cfg_ifm_y = 8'($urandom);
        cfg_fil_x = 8'($urandom); cfg_fil_y = 8'($urandom);
        cfg_out_x = 8'($urandom); cfg_out_y = 8'($urandom); cfg_stride = 2'($urandom);
        if (spur) begin
            spur_end = 1'b1;
            @(negedge clk);
            spur_end = 1'b0;
        end
    endtask

    task automatic run_cfg(input int ch, input int ixd, input int iyd, input int fxd, input int fyd,
                           input int oxd, input int oyd, input int s, input bit spur, input bit restart);
        int nsteps, ngroups, cyc;
        build(ch, ixd, iyd, fxd, fyd, oxd, oyd, s, nsteps, ngroups);
        ifm_seen = 0; fil_seen = 0; done_cnt = 0; start_seen = 0;
        kick_start(ch, ixd, iyd, fxd, fyd, oxd, oyd, s, spur);
        cyc = 0;
        while (done_cnt == 0 && cyc < 20000) begin
            @(negedge clk);
            #1;
            cyc++;
            start_i = (restart && (cyc == 10 || cyc == 40));
        end
        start_i = 1'b0;
        if (done_cnt == 0) begin
            chk("run_timeout", 1, 0);
            flush();
        end
        repeat (3) @(negedge clk);
        #1;
        chk("done_pulses", done_cnt, 1);
        chk("start_count", start_seen, nsteps);
        chk("start_queue_left", st_q.size(), 0);
        chk("ifm_queue_left", ifm_q.size(), 0);
        chk("fil_queue_left", fil_q.size(), 0);
        chk("idle_busy", int'(busy_o), 0);
        chk("idle_run_valid", int'(run_valid_o), 0);
        flush();
        ifm_base ^= nsteps % 2;
        fil_base ^= ngroups % 2;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_busy"}, int'(busy_o), 0);
        chk({tag, "_done"}, int'(done_o), 0);
        chk({tag, "_ifm_valid"}, int'(ifm_chunk_wr_valid_o), 0);
        chk({tag, "_fil_valid"}, int'(fil_chunk_wr_valid_o), 0);
        chk({tag, "_ifm_wr_sel"}, int'(ifm_chunk_wr_sel_o), 1);
        chk({tag, "_ifm_rd_sel"}, int'(ifm_chunk_rd_sel_o), 0);
        chk({tag, "_fil_wr_sel"}, int'(fil_chunk_wr_sel_o), 1);
        chk({tag, "_fil_rd_sel"}, int'(fil_chunk_rd_sel_o), 0);
        chk({tag, "_cu_wr_sel"}, int'(fil_chunk_cu_wr_sel_o), 0);
        chk({tag, "_run_valid"}, int'(run_valid_o), 0);
        chk({tag, "_start"}, int'(total_chunk_start_o), 0);
        chk({tag, "_acc_buf_sel"}, int'(acc_buf_sel_o), 0);
        chk({tag, "_sparsemap_last"}, int'(rd_fil_sparsemap_last_o), 0);
        chk({tag, "_ifm_count"}, int'(ifm_sram_rd_count_o), 0);
        chk({tag, "_fil_count"}, int'(fil_sram_rd_count_o), 0);
    endtask

    initial begin
        int nsteps, ngroups, cyc;
        int oxd, oyd, fxd, fyd, s, se;

        #12;
        chk_reset_values("por");
        #10 rst_i = 1'b1;

        // directed configurations
        run_cfg(128, 4, 4, 3, 3, 2, 2, 1, 1'b1, 1'b0);
        run_cfg(200, 4, 4, 3, 3, 2, 2, 1, 1'b0, 1'b1);
        run_cfg(64, 5, 5, 3, 3, 2, 2, 2, 1'b0, 1'b0);
        run_cfg(255, 4, 3, 2, 1, 3, 3, 0, 1'b0, 1'b0);
        run_cfg(32, 1, 1, 1, 1, 1, 1, 1, 1'b0, 1'b0);

        // randomized configurations
        for (int r = 0; r < 5; r++) begin
            oxd = $urandom_range(1, 3); oyd = $urandom_range(1, 3);
            fxd = $urandom_range(1, 3); fyd = $urandom_range(1, 3);
            s   = $urandom_range(0, 3); se = (s == 0) ? 1 : s;
            run_cfg($urandom_range(1, 255), (oxd - 1) * se + fxd, (oyd - 1) * se + fyd,
                    fxd, fyd, oxd, oyd, s, 1'(r % 2), 1'b0);
        end

        // asynchronous reset while waiting for the cluster
        cluster_en = 1'b0;
        build(128, 4, 4, 3, 3, 2, 2, 1, nsteps, ngroups);
        ifm_seen = 0; fil_seen = 0; done_cnt = 0; start_seen = 0;
        kick_start(128, 4, 4, 3, 3, 2, 2, 1, 1'b0);
        cyc = 0;
        while (start_seen == 0 && cyc < 500) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("mid_run_first_start", start_seen, 1);
        @(negedge clk);
        #2;
        chk("mid_run_prefetch_inflight", int'(ifm_chunk_wr_valid_o), 1);
        chk("mid_run_busy", int'(busy_o), 1);
        rst_i = 1'b0;
        #1;
        chk_reset_values("async_rst");
        flush();
        ifm_base = 1; fil_base = 1;
        repeat (3) @(negedge clk);
        #2;
        chk("held_rst_ifm_valid", int'(ifm_chunk_wr_valid_o), 0);
        rst_i = 1'b1;
        cluster_en = 1'b1;
        run_cfg(200, 4, 4, 3, 3, 2, 2, 1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
